// File: rtl/alu_issue_unit.sv
// Command FIFO in front of an external combinational ALU, with a single result register.
// Optional macro ALU_NOP_FILTER_EN: NOP opcodes (1101-1111) are accepted but dropped.
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_ctrl,
  input  logic [7:0]               in_x,
  input  logic [7:0]               in_y,
  output logic [3:0]               alu_ctrl,
  output logic [7:0]               alu_x,
  output logic [7:0]               alu_y,
  input  logic [7:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_carry,
  output logic [3:0]               out_ctrl,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
  } cmd_t;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [7:0]    out_data_q;
  logic          out_carry_q;
  logic [3:0]    out_ctrl_q;
  logic          push, wr_en, issue, not_empty;
  cmd_t          head;

  assign not_empty = (count_q != '0);
  assign in_ready  = !rst && (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
`ifdef ALU_NOP_FILTER_EN
  // Handshake completes for NOPs, but nothing is queued.
  assign wr_en     = push && (in_ctrl < 4'd13);
`else
  assign wr_en     = push;
`endif
  assign issue     = !rst && not_empty && (!out_valid || out_ready);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    alu_ctrl = 4'b1101;
    alu_x    = 8'h00;
    alu_y    = 8'h00;
    if (not_empty) begin
      alu_ctrl = head.ctrl;
      alu_x    = head.x;
      alu_y    = head.y;
    end
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{ctrl: in_ctrl, x: in_x, y: in_y};
  end

  // Output-register control FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (issue) state_d = S_FULL;
      S_FULL:  if (out_ready && !issue) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= 8'h00;
      out_carry_q <= 1'b0;
      out_ctrl_q  <= 4'b0000;
    end else if (issue) begin
      out_data_q  <= alu_out;
      out_carry_q <= alu_carry;
      out_ctrl_q  <= head.ctrl;
    end
  end

  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_ctrl  = out_ctrl_q;
  assign count     = count_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed scenarios plus a random run against a queue model.
module tb_alu_issue_unit;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 0;
  logic          rst, in_valid, in_ready, out_ready, out_valid, out_carry, alu_carry;
  logic [3:0]    in_ctrl, alu_ctrl, out_ctrl;
  logic [7:0]    in_x, in_y, alu_x, alu_y, alu_out, out_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;

  alu_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_x(in_x), .in_y(in_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_ctrl(out_ctrl),
    .count(count)
  );

  always #5 clk = ~clk;

  // Bench-side ALU: returns {carry, result}
  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      4'd0:    return {1'b0, x} + {1'b0, y};
      4'd1:    return {1'b0, x} - {1'b0, y};
      4'd2:    return {1'b0, x & y};
      4'd3:    return {1'b0, x | y};
      4'd4:    return {1'b0, ~x};
      4'd5:    return {1'b0, x ^ y};
      4'd6:    return {x[7], x << 1};
      4'd7:    return {x[0], x >> 1};
      4'd8:    return {1'b0, x} + 9'd1;
      4'd9:    return {1'b0, x} - 9'd1;
      4'd10:   return {1'b0, y};
      4'd11:   return {1'b0, 7'd0, x < y};
      4'd12:   return {1'b0, 7'd0, x == y};
      default: return 9'h000;
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

  // Reference model: queue of {ctrl,x,y} plus the result register
  logic [19:0] mq[$];
  logic        m_ov;
  logic [7:0]  m_data;
  logic        m_carry;
  logic [3:0]  m_ctrl;

  function automatic bit is_dropped(input logic [3:0] c);
`ifdef ALU_NOP_FILTER_EN
    return c >= 4'd13;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    bit          p, iss;
    logic [19:0] cmd, h;
    logic [8:0]  r;
    p   = in_valid && !rst && (mq.size() != DEPTH);
    iss = !rst && (mq.size() != 0) && (!m_ov || out_ready);
    cmd = {in_ctrl, in_x, in_y};
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ov = 0; m_data = 0; m_carry = 0; m_ctrl = 0;
    end else begin
      if (iss) begin
        h = mq.pop_front();
        r = alu_fn(h[19:16], h[15:8], h[7:0]);
        m_ov = 1; m_data = r[7:0]; m_carry = r[8]; m_ctrl = h[19:16];
      end else if (m_ov && out_ready) m_ov = 0;
      if (p && !is_dropped(cmd[19:16])) mq.push_back(cmd);
    end
    #1;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (DEPTH + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; in_ctrl = 0; in_x = 0; in_y = 0;
    m_ov = 0; m_data = 0; m_carry = 0; m_ctrl = 0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    rst = 0; #1;
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00 || out_ctrl !== 4'h0 || out_carry !== 1'b0)
      begin bad++; $display("FAIL reset_out_regs got=%h/%h/%b want=00/0/0", out_data, out_ctrl, out_carry); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_ctrl = 4'b0010; in_x = 8'h61; in_y = 8'hE3;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b0 || count !== CW'(1))
      begin bad++; $display("FAIL single_edge0 got=ov%b cnt%0d want=ov0 cnt1", out_valid, count); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h61 || out_ctrl !== 4'b0010)
      begin bad++; $display("FAIL single_result got=ov%b %h/%h want=ov1 61/2", out_valid, out_data, out_ctrl); end
    drain();
  endtask

  task automatic test_fill();
    logic [19:0] cmds[$];
    logic [8:0]  r;
    out_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1;
      if (i == 0) {in_ctrl, in_x, in_y} = {4'b0011, 8'h61, 8'hE3};
      else begin
        in_ctrl = 4'($urandom_range(0, 12)); in_x = 8'($urandom); in_y = 8'($urandom);
      end
      cmds.push_back({in_ctrl, in_x, in_y});
      tick();
    end
    in_valid = 0; #1;
    total++; if (in_ready !== 1'b0 || count !== CW'(DEPTH))
      begin bad++; $display("FAIL fill_full got=rdy%b cnt%0d want=rdy0 cnt%0d", in_ready, count, DEPTH); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hE3)
      begin bad++; $display("FAIL fill_head got=ov%b %h want=ov1 e3", out_valid, out_data); end
    out_ready = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      r = alu_fn(cmds[i][19:16], cmds[i][15:8], cmds[i][7:0]);
      total++; if (out_valid !== 1'b1 || out_data !== r[7:0] || out_ctrl !== cmds[i][19:16])
        begin bad++; $display("FAIL fill_order%0d got=ov%b %h/%h want=ov1 %h/%h", i, out_valid, out_data, out_ctrl, r[7:0], cmds[i][19:16]); end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int nval = 0, first = -1, last = -1, nbad = 0;
    out_ready = 1; in_ctrl = 4'b0100; in_x = 8'h61;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 8); in_y = 8'($urandom);
      tick();
      if (out_valid) begin
        nval++; if (first < 0) first = i; last = i;
        if (out_data !== 8'h9E) nbad++;
      end
    end
    in_valid = 0;
    total++; if (nval != 8 || last - first + 1 != 8)
      begin bad++; $display("FAIL b2b_count got=%0d span=%0d want=8", nval, last - first + 1); end
    total++; if (nbad != 0) begin bad++; $display("FAIL b2b_data got=%0d wrong want=0", nbad); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_ctrl = 4'($urandom_range(0, 12)); in_x = 8'($urandom | 1); in_y = 8'($urandom);
      tick();
    end
    total++; if (count !== CW'(3) || out_valid !== 1'b1)
      begin bad++; $display("FAIL rstmid_pre got=cnt%0d ov%b want=cnt3 ov1", count, out_valid); end
    rst = 1; in_valid = 1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready_hi got=%b want=0", in_ready); end
    rst = 0; in_valid = 0; #1;
    total++; if (count !== '0 || out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rstmid_post got=cnt%0d ov%b %h rdy%b want=cnt0 ov0 00 rdy1", count, out_valid, out_data, in_ready); end
  endtask

  task automatic test_nop();
    logic [7:0] res[$];
    logic [7:0] exp[$];
`ifdef ALU_NOP_FILTER_EN
    exp = '{8'h61};
`else
    exp = '{8'h00, 8'h61};
`endif
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 2);
      if (i == 0) {in_ctrl, in_x, in_y} = {4'b1110, 8'h61, 8'hE3};
      else        {in_ctrl, in_x, in_y} = {4'b0010, 8'h61, 8'hE3};
      tick();
      if (out_valid) res.push_back(out_data);
    end
    in_valid = 0;
    total++; if (res.size() != exp.size())
      begin bad++; $display("FAIL nop_count got=%0d want=%0d", res.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      total++; if (res[i] !== exp[i]) begin bad++; $display("FAIL nop_result%0d got=%h want=%h", i, res[i], exp[i]); end
    end
    drain();
  endtask

  task automatic test_random();
    int nbad = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      in_ctrl = 4'($urandom); in_x = 8'($urandom); in_y = 8'($urandom);
      tick();
      total++;
      if (out_valid !== m_ov || count !== CW'(mq.size()) || in_ready !== (mq.size() != DEPTH) ||
          (m_ov && (out_data !== m_data || out_carry !== m_carry || out_ctrl !== m_ctrl))) begin
        bad++; nbad++;
        if (nbad < 10)
          $display("FAIL random_cyc%0d got=ov%b cnt%0d rdy%b %h/%b/%h want=ov%b cnt%0d %h/%b/%h",
                   i, out_valid, count, in_ready, out_data, out_carry, out_ctrl,
                   m_ov, mq.size(), m_data, m_carry, m_ctrl);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_nop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
